mips_instr_encoder: RTL and testbench

MIPS_INSTR_ENCODER -- requirements
Module: mips_instr_encoder

---
 rtl/mips_instr_encoder.sv | 144 ++++++++++++++
 tb/tb_mips_instr_encoder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mips_instr_encoder.sv
// MIPS instruction encoder: packs mnemonic + fields into 32-bit words, buffers
// them in a 4-deep FIFO and streams them to instruction memory. Optional op check: ENC_CHECK_EN.
module mips_instr_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic        imem_we,
  input  logic        imem_ready,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic [15:0] count,
  output logic        err
);

  logic [31:0] enc_word;
  logic        enc_legal;

  always_comb begin
    enc_word  = 32'h0000_0000;
    enc_legal = 1'b1;
    case (op)
      5'd0:  enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
      5'd1:  enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100010};
      5'd2:  enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100100};
      5'd3:  enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100101};
      5'd4:  enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b101010};
      5'd5:  enc_word = {6'b000000, rs, 5'd0, 5'd0, 5'b00000, 6'b001000};
      5'd6:  enc_word = {6'b100011, rs, rt, imm};
      5'd7:  enc_word = {6'b100000, rs, rt, imm};
      5'd8:  enc_word = {6'b100001, rs, rt, imm};
      5'd9:  enc_word = {6'b101011, rs, rt, imm};
      5'd10: enc_word = {6'b101000, rs, rt, imm};
      5'd11: enc_word = {6'b101001, rs, rt, imm};
      5'd12: enc_word = {6'b001000, rs, rt, imm};
      5'd13: enc_word = {6'b001100, rs, rt, imm};
      5'd14: enc_word = {6'b001101, rs, rt, imm};
      5'd15: enc_word = {6'b001010, rs, rt, imm};
      5'd16: enc_word = {6'b001111, 5'd0, rt, imm};
      5'd17: enc_word = {6'b000010, target};
      5'd18: enc_word = {6'b000011, target};
      5'd19: enc_word = {6'b000100, rs, rt, imm};
      5'd20: enc_word = {6'b000101, rs, rt, imm};
      default: begin
        enc_word  = 32'h0000_0000;
        enc_legal = 1'b0;
      end
    endcase
  end

  logic [31:0] fifo_q [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  occ_q, occ_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] count_q, count_d;
  logic        err_q, err_d;
  logic        full, accept, push, pop;

  assign full     = (occ_q == 3'd4);
  assign in_ready = !full && !start;
  assign accept   = in_valid && in_ready;
  assign imem_we  = (occ_q != 3'd0);
  assign pop      = imem_we && imem_ready && !start;

`ifdef ENC_CHECK_EN
  assign push = accept && enc_legal;
`else
  assign push = accept;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    addr_d   = addr_q;
    count_d  = count_q;
    err_d    = err_q;
    if (start) begin
      wr_ptr_d = 2'd0;
      rd_ptr_d = 2'd0;
      occ_d    = 3'd0;
      addr_d   = base_addr;
      count_d  = 16'd0;
      err_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 2'd1;
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 2'd1;
        addr_d   = addr_q + 32'd4;
        if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
      end
      case ({push, pop})
        2'b10:   occ_d = occ_q + 3'd1;
        2'b01:   occ_d = occ_q - 3'd1;
        default: occ_d = occ_q;
      endcase
`ifdef ENC_CHECK_EN
      if (accept && !enc_legal) err_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      occ_q    <= 3'd0;
      addr_q   <= 32'd0;
      count_q  <= 16'd0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Storage needs no reset: the occupancy counter decides what is valid.
  always_ff @(posedge clk) begin
    if (push && !start) fifo_q[wr_ptr_q] <= enc_word;
  end

  assign imem_wdata = imem_we ? fifo_q[rd_ptr_q] : 32'h0000_0000;
  assign imem_addr  = addr_q;
  assign count      = count_q;
`ifdef ENC_CHECK_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed-vector bench for mips_instr_encoder; writes are logged at the falling edge.
module tb_mips_instr_encoder;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_ready, imem_we, imem_ready, err;
  logic [31:0] base_addr, imem_addr, imem_wdata;
  logic [4:0]  op, rs, rt, rd;
  logic [15:0] imm, count;
  logic [25:0] target;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  always #5 clk = ~clk;

  mips_instr_encoder dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .op(op), .rs(rs), .rt(rt),
    .rd(rd), .imm(imm), .target(target), .imem_we(imem_we),
    .imem_ready(imem_ready), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .err(err)
  );

  // Inputs only change just after a rising edge, so this sees what the edge will see.
  always @(negedge clk) begin
    if (!reset && imem_we && imem_ready && !start) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
  endtask

  task automatic clear_logs();
    exp_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic do_start(input logic [31:0] base);
    start     = 1'b1;
    base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
    clear_logs();
  endtask

  task automatic set_fields(input logic [4:0] o, a, b, c, input logic [15:0] im,
                            input logic [25:0] tg);
    op = o; rs = a; rt = b; rd = c; imm = im; target = tg;
  endtask

  task automatic push_word(input logic [4:0] o, a, b, c, input logic [15:0] im,
                           input logic [25:0] tg, input logic [31:0] expw, input bit queued);
    bit accepted = 0;
    set_fields(o, a, b, c, im, tg);
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(negedge clk);
      if (in_ready) accepted = 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check($sformatf("accept_op%0d", o), {31'd0, accepted}, 32'd1);
    if (queued) exp_q.push_back(expw);
    $display("push op=%0d rs=%0d rt=%0d rd=%0d imm=%04h tgt=%07h exp=%08h", o, a, b, c, im, tg, expw);
  endtask

  task automatic check_writes(input logic [31:0] base);
    for (int i = 0; i < 50 && wr_data_q.size() < exp_q.size(); i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("write_count", wr_data_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_data_q.size(); i++) begin
      check($sformatf("wdata[%0d]", i), wr_data_q[i], exp_q[i]);
      check($sformatf("waddr[%0d]", i), wr_addr_q[i], base + 32'(4 * i));
      $display("write addr=%08h data=%08h", wr_addr_q[i], wr_data_q[i]);
    end
    clear_logs();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = 32'd0; in_valid = 1'b0;
    imem_ready = 1'b0;
    set_fields(5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    repeat (3) @(posedge clk); #1;
    check("rst_we", {31'd0, imem_we}, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_count", {16'd0, count}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_ready", {31'd0, in_ready}, 32'd1);

    // First word latency and address/count advance
    do_start(32'h0040_0000);
    check("start_addr", imem_addr, 32'h0040_0000);
    imem_ready = 1'b1;
    push_word(5'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 32'h0022_1820, 1'b0);
    check("lat_we", {31'd0, imem_we}, 32'd1);
    check("lat_wdata", imem_wdata, 32'h0022_1820);
    check("lat_addr", imem_addr, 32'h0040_0000);
    @(posedge clk); #1;
    check("post_addr", imem_addr, 32'h0040_0004);
    check("post_count", {16'd0, count}, 32'd1);
    check("post_we", {31'd0, imem_we}, 32'd0);

    // Encoding table, streamed back-to-back
    do_start(32'h0000_1000);
    push_word(5'd6,  5'd29, 5'd8,  5'd0, 16'hFFFC, 26'd0, 32'h8FA8_FFFC, 1'b1);
    push_word(5'd17, 5'd0,  5'd0,  5'd0, 16'd0, 26'h010_0000, 32'h0810_0000, 1'b1);
    push_word(5'd5,  5'd31, 5'd5,  5'd7, 16'd0, 26'd0, 32'h03E0_0008, 1'b1);
    push_word(5'd7,  5'd2,  5'd3,  5'd0, 16'h0004, 26'd0, 32'h8043_0004, 1'b1);
    push_word(5'd8,  5'd2,  5'd3,  5'd0, 16'h0006, 26'd0, 32'h8443_0006, 1'b1);
    push_word(5'd9,  5'd29, 5'd31, 5'd0, 16'h0008, 26'd0, 32'hAFBF_0008, 1'b1);
    push_word(5'd10, 5'd1,  5'd2,  5'd0, 16'h0001, 26'd0, 32'hA022_0001, 1'b1);
    push_word(5'd11, 5'd1,  5'd2,  5'd0, 16'h0002, 26'd0, 32'hA422_0002, 1'b1);
    push_word(5'd15, 5'd1,  5'd2,  5'd0, 16'h8000, 26'd0, 32'h2822_8000, 1'b1);
    push_word(5'd20, 5'd3,  5'd4,  5'd0, 16'h0010, 26'd0, 32'h1464_0010, 1'b1);
    push_word(5'd18, 5'd0,  5'd0,  5'd0, 16'd0, 26'h3FF_FFFF, 32'h0FFF_FFFF, 1'b1);
    push_word(5'd2,  5'd1,  5'd2,  5'd3, 16'd0, 26'd0, 32'h0022_1824, 1'b1);
    push_word(5'd3,  5'd1,  5'd2,  5'd3, 16'd0, 26'd0, 32'h0022_1825, 1'b1);
    check_writes(32'h0000_1000);
    check("table_count", {16'd0, count}, 32'd13);

    // Backpressure: fill FIFO, hold fifth word, then drain
    do_start(32'h0000_2000);
    imem_ready = 1'b0;
    push_word(5'd12, 5'd1, 5'd2, 5'd0, 16'h0005, 26'd0, 32'h2022_0005, 1'b1);
    push_word(5'd13, 5'd3, 5'd4, 5'd0, 16'h00FF, 26'd0, 32'h3064_00FF, 1'b1);
    push_word(5'd14, 5'd0, 5'd5, 5'd0, 16'h1234, 26'd0, 32'h3405_1234, 1'b1);
    push_word(5'd16, 5'd9, 5'd6, 5'd0, 16'hABCD, 26'd0, 32'h3C06_ABCD, 1'b1);
    check("full_ready", {31'd0, in_ready}, 32'd0);
    set_fields(5'd19, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'd0);
    in_valid = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("hold_ready", {31'd0, in_ready}, 32'd0);
    check("hold_we", {31'd0, imem_we}, 32'd1);
    check("hold_addr", imem_addr, 32'h0000_2000);
    check("hold_wdata", imem_wdata, 32'h2022_0005);
    imem_ready = 1'b1;
    push_word(5'd19, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'd0, 32'h1022_FFFF, 1'b1);
    check_writes(32'h0000_2000);
    check("bp_count", {16'd0, count}, 32'd5);

    // Address wrap
    do_start(32'hFFFF_FFFC);
    push_word(5'd1, 5'd4, 5'd5, 5'd6, 16'd0, 26'd0, 32'h0085_3022, 1'b1);
    push_word(5'd4, 5'd7, 5'd8, 5'd9, 16'd0, 26'd0, 32'h00E8_482A, 1'b1);
    check_writes(32'hFFFF_FFFC);
    check("wrap_addr", imem_addr, 32'h0000_0004);

    // Illegal op
    do_start(32'h0000_3000);
`ifdef ENC_CHECK_EN
    push_word(5'd25, 5'd1, 5'd2, 5'd3, 16'h1111, 26'd0, 32'h0, 1'b0);
    check_writes(32'h0000_3000);
    check("ill_err", {31'd0, err}, 32'd1);
    check("ill_count", {16'd0, count}, 32'd0);
    do_start(32'h0000_3000);
    check("ill_err_clr", {31'd0, err}, 32'd0);
`else
    push_word(5'd25, 5'd1, 5'd2, 5'd3, 16'h1111, 26'd0, 32'h0, 1'b1);
    check_writes(32'h0000_3000);
    check("ill_err", {31'd0, err}, 32'd0);
    check("ill_count", {16'd0, count}, 32'd1);
`endif

    // Reset mid-operation discards queued words
    do_start(32'h0000_4000);
    imem_ready = 1'b0;
    push_word(5'd0, 5'd1, 5'd1, 5'd1, 16'd0, 26'd0, 32'h0, 1'b0);
    push_word(5'd1, 5'd2, 5'd2, 5'd2, 16'd0, 26'd0, 32'h0, 1'b0);
    push_word(5'd2, 5'd3, 5'd3, 5'd3, 16'd0, 26'd0, 32'h0, 1'b0);
    imem_ready = 1'b1;
    reset = 1'b1;
    #1;
    check("mid_rst_we", {31'd0, imem_we}, 32'd0);
    check("mid_rst_addr", imem_addr, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rst_count", {16'd0, count}, 32'd0);
    @(posedge clk); #1;
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    check_writes(32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
